// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
// Shared limits and helpers for the DSP operand-alignment blocks.
//   MAX_DEPTH      : deepest supported delay line
//   MAX_DATA_WIDTH : widest supported data word
//   clog2_min1()   : ceil(log2(v)) clamped to at least 1, used to size counters
// ----------------------------------------------------------------------------
package dsp_pkg;

    localparam int MAX_DEPTH      = 8;
    localparam int MAX_DATA_WIDTH = 48;

    // Bits needed to hold values 0..v-1; never returns 0 so a counter port
    // always has at least one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
// One register stage of the delay line: a W-bit data register plus a valid
// flag, advancing on CE and cleared by a synchronous active-high reset.
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high, wins over CE
//   CE         clock enable; the stage holds when low
//   din        data word from the previous stage
//   din_valid  valid flag from the previous stage
//   dout       registered data word
//   dout_valid registered valid flag
// ----------------------------------------------------------------------------
module pipe_stage #(
    parameter int W = 18
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    logic [W-1:0] data_reg;
    logic         vld_reg;

    // Data loads even for bubbles; downstream logic qualifies with the valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg <= '0;
            vld_reg  <= 1'b0;
        end else if (CE) begin
            data_reg <= din;
            vld_reg  <= din_valid;
        end
    end

    assign dout       = data_reg;
    assign dout_valid = vld_reg;

endmodule

// File: rtl/pipe_delay_buffer.sv
// ----------------------------------------------------------------------------
// pipe_delay_buffer
// Valid-tracked data delay line of DEPTH register stages used to align operand
// paths ahead of the DSP48A1 pre-adder / multiplier / post-adder. DEPTH=0 is a
// plain combinational buffer.
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high (clears stages and count)
//   CE         clock enable; every stage advances together only when high
//   din        input word
//   din_valid  qualifies din
//   dout       word delayed by DEPTH CE-high edges
//   dout_valid qualifies dout
//   inflight   number of valid words currently held in the stages
//   parity_err (only with PIPE_DELAY_PARITY_EN) registered one-cycle flag when
//              a valid output word fails its carried even-parity bit
// Build option:
//   PIPE_DELAY_PARITY_EN  adds a parity bit per stage and the parity_err port.
// ----------------------------------------------------------------------------
module pipe_delay_buffer
    import dsp_pkg::*;
#(
    parameter  int DATA_WIDTH = 18,
    parameter  int DEPTH      = 2,
    localparam int CNT_W      = clog2_min1(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [CNT_W-1:0]      inflight
`ifdef PIPE_DELAY_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef PIPE_DELAY_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SW = DATA_WIDTH + PAR_W;

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout       = din;
            assign dout_valid = din_valid;
            assign inflight   = '0;
`ifdef PIPE_DELAY_PARITY_EN
            assign parity_err = 1'b0;
`endif
            // Clock, reset and enable have no function in the pass-through.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, CLK, RST, CE};
        end else begin : g_pipe
            // Index 0 is the stage input; index gi+1 is the output of stage gi.
            logic [SW-1:0] sd [0:DEPTH];
            logic          sv [0:DEPTH];
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

`ifdef PIPE_DELAY_PARITY_EN
            assign sd[0] = {^din, din};
`else
            assign sd[0] = din;
`endif
            assign sv[0] = din_valid;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                pipe_stage #(
                    .W(SW)
                ) u_stage (
                    .CLK        (CLK),
                    .RST        (RST),
                    .CE         (CE),
                    .din        (sd[gi]),
                    .din_valid  (sv[gi]),
                    .dout       (sd[gi+1]),
                    .dout_valid (sv[gi+1])
                );
            end

            assign dout       = sd[DEPTH][DATA_WIDTH-1:0];
            assign dout_valid = sv[DEPTH];

            // Occupancy tracks the popcount of the valid flags: a shift moves
            // din_valid in and the last stage's flag out, so only the
            // in/out mismatch changes the count.
            always_comb begin
                cnt_next = cnt_reg;
                if (CE) begin
                    if (din_valid && !sv[DEPTH]) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else if (!din_valid && sv[DEPTH]) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign inflight = cnt_reg;

`ifdef PIPE_DELAY_PARITY_EN
            logic parity_err_reg;

            // Checks the word presented on dout at each advancing edge, so the
            // flag is a single CE-high cycle wide.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    parity_err_reg <= 1'b0;
                end else if (CE) begin
                    parity_err_reg <= sv[DEPTH] &&
                        ((^sd[DEPTH][DATA_WIDTH-1:0]) != sd[DEPTH][DATA_WIDTH]);
                end else begin
                    parity_err_reg <= 1'b0;
                end
            end

            assign parity_err = parity_err_reg;
`endif
        end
    endgenerate

endmodule
